// File: rtl/alu_pkg.sv
// Shared constants for the alu command path: operand widths, alu mode codes
// and the sequencer FSM state encodings.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int RES_W_DEFAULT  = 16;

    localparam logic [1:0] MODE_ADD   = 2'b00;
    localparam logic [1:0] MODE_MUL   = 2'b01;
    localparam logic [1:0] MODE_DEC   = 2'b10;
    localparam logic [1:0] MODE_PASSB = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, alu and result bus of alu_cmd_sequencer. Status flag signals exist
// only when STATUS_FLAGS_EN is defined.
interface alu_cmd_sequencer_if #(
    parameter int DATA_W = alu_pkg::DATA_W_DEFAULT,
    parameter int RES_W  = alu_pkg::RES_W_DEFAULT
);
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [DATA_W-1:0] i_cmd_a;
    logic [DATA_W-1:0] i_cmd_b;
    logic [1:0]        i_cmd_mode;
    logic [DATA_W-1:0] o_alu_a;
    logic [DATA_W-1:0] o_alu_b;
    logic [1:0]        o_alu_mode;
    logic [RES_W-1:0]  i_alu_out;
    logic              o_res_valid;
    logic              i_res_ready;
    logic [RES_W-1:0]  o_res_data;
    logic              o_busy;
    logic [7:0]        o_op_cnt;
`ifdef STATUS_FLAGS_EN
    logic              o_res_zero;
    logic              o_res_wide;
`endif

    // slave: the sequencer itself; master: the surrounding environment
    modport slave (
        input  i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_mode, i_alu_out, i_res_ready,
`ifdef STATUS_FLAGS_EN
        output o_res_zero, o_res_wide,
`endif
        output o_cmd_ready, o_alu_a, o_alu_b, o_alu_mode, o_res_valid, o_res_data,
               o_busy, o_op_cnt
    );

    modport master (
        output i_cmd_valid, i_cmd_a, i_cmd_b, i_cmd_mode, i_alu_out, i_res_ready,
`ifdef STATUS_FLAGS_EN
        input  o_res_zero, o_res_wide,
`endif
        input  o_cmd_ready, o_alu_a, o_alu_b, o_alu_mode, o_res_valid, o_res_data,
               o_busy, o_op_cnt
    );

endinterface

// File: rtl/alu_cmd_sequencer.sv
// Single-outstanding command stage for the combinational alu: register operands,
// wait WAIT_CYCLES edges, capture the result, hand it downstream. Option: STATUS_FLAGS_EN.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEFAULT,
    parameter int RES_W       = RES_W_DEFAULT,
    parameter int WAIT_CYCLES = 1
) (
    input logic           i_clk,
    input logic           i_rst,
    alu_cmd_sequencer_if.slave bus
);

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_mode;
    logic [RES_W-1:0]  res_data;
    logic [7:0]        op_cnt;
`ifdef STATUS_FLAGS_EN
    logic              res_zero;
    logic              res_wide;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
            res_data <= '0;
            op_cnt   <= '0;
`ifdef STATUS_FLAGS_EN
            res_zero <= 1'b0;
            res_wide <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        alu_a    <= bus.i_cmd_a;
                        alu_b    <= bus.i_cmd_b;
                        alu_mode <= bus.i_cmd_mode;
                        cnt      <= CNT_W'(WAIT_CYCLES);
                        state    <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt == CNT_W'(1)) begin
                        res_data <= bus.i_alu_out;
`ifdef STATUS_FLAGS_EN
                        res_zero <= (bus.i_alu_out == '0);
                        res_wide <= |bus.i_alu_out[RES_W-1:DATA_W];
`endif
                        state    <= ST_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.i_res_ready) begin
                        op_cnt <= op_cnt + 8'd1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Ready is gated by reset so it reads 0 while reset is asserted.
    assign bus.o_cmd_ready = (state == ST_IDLE) && !i_rst;
    assign bus.o_busy      = (state == ST_SETTLE) || (state == ST_DONE);
    assign bus.o_res_valid = (state == ST_DONE);
    assign bus.o_alu_a     = alu_a;
    assign bus.o_alu_b     = alu_b;
    assign bus.o_alu_mode  = alu_mode;
    assign bus.o_res_data  = res_data;
    assign bus.o_op_cnt    = op_cnt;
`ifdef STATUS_FLAGS_EN
    assign bus.o_res_zero  = res_zero;
    assign bus.o_res_wide  = res_wide;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer with a behavioural alu and a
// transaction-level model compared every cycle; STATUS_FLAGS_EN adds flag tests.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    localparam int W = 3;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 i_clk = ~i_clk;

    alu_cmd_sequencer_if #(.DATA_W(8), .RES_W(16)) bus ();

    alu_cmd_sequencer #(.DATA_W(8), .RES_W(16), .WAIT_CYCLES(W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                          input logic [1:0] m);
        case (m)
            MODE_ADD: alu_f = {8'd0, a} + {8'd0, b};
            MODE_MUL: alu_f = {8'd0, a} * {8'd0, b};
            MODE_DEC: alu_f = {8'd0, a} - 16'd1;
            default:  alu_f = {8'd0, b};
        endcase
    endfunction

    assign bus.i_alu_out = alu_f(bus.o_alu_a, bus.o_alu_b, bus.o_alu_mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: an accepted command occupies the block; its result
    // appears W edges later and leaves on the first edge with res_ready.
    logic        m_busy, m_valid;
    int          m_age;
    logic [7:0]  m_a, m_b, m_cnt;
    logic [1:0]  m_mode;
    logic [15:0] m_res;

    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            m_busy <= 1'b0; m_valid <= 1'b0; m_age <= 0;
            m_a <= '0; m_b <= '0; m_mode <= '0; m_res <= '0; m_cnt <= '0;
        end else if (!m_busy) begin
            if (bus.i_cmd_valid) begin
                m_busy <= 1'b1; m_age <= 0;
                m_a <= bus.i_cmd_a; m_b <= bus.i_cmd_b; m_mode <= bus.i_cmd_mode;
            end
        end else if (!m_valid) begin
            m_age <= m_age + 1;
            if (m_age + 1 == W) begin
                m_valid <= 1'b1;
                m_res   <= alu_f(m_a, m_b, m_mode);
            end
        end else if (bus.i_res_ready) begin
            m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= m_cnt + 8'd1;
        end
    end

    always @(negedge i_clk) begin
        check("cmd_ready", 32'(bus.o_cmd_ready), 32'(!i_rst && !m_busy));
        check("busy",      32'(bus.o_busy),      32'(m_busy));
        check("res_valid", 32'(bus.o_res_valid), 32'(m_valid));
        check("res_data",  32'(bus.o_res_data),  32'(m_res));
        check("alu_a",     32'(bus.o_alu_a),     32'(m_a));
        check("alu_b",     32'(bus.o_alu_b),     32'(m_b));
        check("alu_mode",  32'(bus.o_alu_mode),  32'(m_mode));
        check("op_cnt",    32'(bus.o_op_cnt),    32'(m_cnt));
`ifdef STATUS_FLAGS_EN
        check("res_zero",  32'(bus.o_res_zero),  32'(m_res == 16'd0));
        check("res_wide",  32'(bus.o_res_wide),  32'(|m_res[15:8]));
`endif
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m);
        int k = 0;
        @(negedge i_clk);
        while (!bus.o_cmd_ready && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        if (!bus.o_cmd_ready) check("cmd_ready_timeout", 32'(0), 32'(1));
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_a     = a;
        bus.i_cmd_b     = b;
        bus.i_cmd_mode  = m;
        @(posedge i_clk);
        #1 bus.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [15:0] exp);
        int k = 0;
        while (!bus.o_res_valid && k < 50) begin
            @(negedge i_clk);
            k++;
        end
        if (!bus.o_res_valid) check("res_valid_timeout", 32'(0), 32'(1));
        check(name, 32'(bus.o_res_data), 32'(exp));
        @(posedge i_clk);
    endtask

    initial begin
        int n;
        logic [7:0] ra, rb;
        logic [1:0] rm;
        bus.i_cmd_valid = 1'b0; bus.i_cmd_a = '0; bus.i_cmd_b = '0;
        bus.i_cmd_mode = '0; bus.i_res_ready = 1'b1;

        #12;
        check("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'(0));
        check("rst_res_data",  32'(bus.o_res_data),  32'(0));
        check("rst_op_cnt",    32'(bus.o_op_cnt),    32'(0));
        @(negedge i_clk); i_rst = 1'b0;
        #1 check("ready_after_rst", 32'(bus.o_cmd_ready), 32'(1));

        // Asynchronous reset in the middle of SETTLE discards the operation
        send(8'd7, 8'd3, MODE_ADD);
        check("settle_alu_a", 32'(bus.o_alu_a), 32'(7));
        #3 i_rst = 1'b1;
        #1;
        check("arst_alu_a",     32'(bus.o_alu_a),     32'(0));
        check("arst_busy",      32'(bus.o_busy),      32'(0));
        check("arst_res_valid", 32'(bus.o_res_valid), 32'(0));
        check("arst_cmd_ready", 32'(bus.o_cmd_ready), 32'(0));
        @(negedge i_clk); i_rst = 1'b0;
        repeat (6) @(negedge i_clk);
        check("arst_no_result", 32'(bus.o_res_valid), 32'(0));
        check("arst_op_cnt",    32'(bus.o_op_cnt),    32'(0));

        // First op: latency and result
        send(8'd10, 8'd5, MODE_ADD);
        n = 0;
        while (!bus.o_res_valid && n < 50) begin
            @(posedge i_clk);
            #1 n++;
        end
        check("latency", 32'(n), 32'(W));
        wait_result("add_10_5", 16'd15);
        #1 check("op_cnt_1", 32'(bus.o_op_cnt), 32'(1));

        send(8'd10, 8'd5, MODE_MUL);   wait_result("mul_10_5", 16'd50);
        send(8'd10, 8'd5, MODE_DEC);   wait_result("dec_10",   16'd9);
        send(8'd10, 8'd5, MODE_PASSB); wait_result("passb_5",  16'd5);
        #1 check("op_cnt_4", 32'(bus.o_op_cnt), 32'(4));

        // Backpressure: result and alu operands hold while the cmd bus churns
        bus.i_res_ready = 1'b0;
        send(8'd10, 8'd5, MODE_ADD);
        repeat (W) @(negedge i_clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            bus.i_cmd_valid = 1'b1;
            bus.i_cmd_a = 8'($urandom);
            bus.i_cmd_b = 8'($urandom);
            check("bp_res_valid", 32'(bus.o_res_valid), 32'(1));
            check("bp_res_data",  32'(bus.o_res_data),  32'(15));
            check("bp_alu_a",     32'(bus.o_alu_a),     32'(10));
            check("bp_alu_b",     32'(bus.o_alu_b),     32'(5));
        end
        @(negedge i_clk);
        bus.i_cmd_valid = 1'b0;
        bus.i_res_ready = 1'b1;
        @(posedge i_clk);
        #1 check("bp_released", 32'(bus.o_res_valid), 32'(0));
        repeat (3) @(negedge i_clk);
        check("bp_op_cnt_5", 32'(bus.o_op_cnt), 32'(5));

        // 252 further ops bring the total to 257, wrapping the counter to 1
        for (int i = 0; i < 252; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rm = 2'($urandom);
            send(ra, rb, rm);
            wait_result("rand_op", alu_f(ra, rb, rm));
        end
        #1 check("op_cnt_wrap", 32'(bus.o_op_cnt), 32'(1));

`ifdef STATUS_FLAGS_EN
        send(8'd0, 8'd0, MODE_ADD);
        repeat (W) @(negedge i_clk);
        check("flag_zero_0", 32'(bus.o_res_zero), 32'(1));
        check("flag_wide_0", 32'(bus.o_res_wide), 32'(0));
        wait_result("add_0_0", 16'd0);
        send(8'd20, 8'd20, MODE_MUL);
        repeat (W) @(negedge i_clk);
        check("flag_zero_400", 32'(bus.o_res_zero), 32'(0));
        check("flag_wide_400", 32'(bus.o_res_wide), 32'(1));
        wait_result("mul_20_20", 16'd400);
`endif

        repeat (3) @(negedge i_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
